window5_gen: RTL

Streaming 1-D five-tap window generator for the haze-removal pipeline. Sits directly upstream of the five-input minimum stage. It accepts one 10-bit sample per handshake and emits, for every sample position x of a line, the taps x-2..x+2 on `corrouti1`..`corrouti5`, with a one-cycle `win_valid` strobe that drives the downstream `Enable`. Line borders are handled by edge replication, so every line of LINE_WIDTH samples yields exactly LINE_WIDTH windows.

---
 rtl/window5_gen_if.sv | 40 ++++
 rtl/window5_gen.sv | 112 +++++++++++
 2 files changed

// File: rtl/window5_gen_if.sv
// Sample-in / window-out bundle of the five-tap window generator.
// The producer/consumer side uses master; the generator uses slave.
interface window5_gen_if;
    logic [9:0] pixel_in;
    logic       pixel_valid;
    logic       pixel_ready;
    logic [9:0] corrouti1;
    logic [9:0] corrouti2;
    logic [9:0] corrouti3;
    logic [9:0] corrouti4;
    logic [9:0] corrouti5;
    logic       win_valid;
    logic       line_done;

    modport master (
        output pixel_in,
        output pixel_valid,
        input  pixel_ready,
        input  corrouti1,
        input  corrouti2,
        input  corrouti3,
        input  corrouti4,
        input  corrouti5,
        input  win_valid,
        input  line_done
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid,
        output pixel_ready,
        output corrouti1,
        output corrouti2,
        output corrouti3,
        output corrouti4,
        output corrouti5,
        output win_valid,
        output line_done
    );
endinterface

// File: rtl/window5_gen.sv
// Streaming five-tap window generator with edge replication at both line borders.
// Two flush cycles after each line emit the windows whose right neighbours lie past the edge.
module window5_gen #(
    parameter int LINE_WIDTH = 640
) (
    input  logic         clock,
    input  logic         reset,
    window5_gen_if.slave bus
);
    localparam int CW = $clog2(LINE_WIDTH);
    localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] LAST_COL = CW'(LINE_WIDTH - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH1 = 2'd1,
        FLUSH2 = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [CW-1:0]   col_r;
    logic [CW-1:0]   col_nx_s;
    // Element 0 is the oldest tap (x-2), element 4 the newest (x+2).
    logic [4:0][9:0] taps_r;
    logic [4:0][9:0] taps_nx_s;
    logic            win_valid_r;
    logic            win_valid_nx_s;
    logic            line_done_r;
    logic            line_done_nx_s;
    logic            ready_r;
    logic            ready_nx_s;
    logic            xfer_s;

    assign xfer_s = bus.pixel_valid & ready_r;

    // Next-state, tap shifting and strobe decode.
    always_comb begin
        state_nx_s     = state_r;
        col_nx_s       = col_r;
        taps_nx_s      = taps_r;
        win_valid_nx_s = 1'b0;
        line_done_nx_s = 1'b0;
        case (state_r)
            RUN: begin
                if (xfer_s) begin
                    if (col_r == COL_ZERO) begin
                        // Left border: the first sample fills every tap.
                        taps_nx_s      = {5{bus.pixel_in}};
                        win_valid_nx_s = 1'b0;
                    end else begin
                        taps_nx_s      = {bus.pixel_in, taps_r[4:1]};
                        win_valid_nx_s = (col_r >= CW'(2));
                    end
                    if (col_r == LAST_COL) begin
                        col_nx_s   = COL_ZERO;
                        state_nx_s = FLUSH1;
                    end else begin
                        col_nx_s   = col_r + CW'(1);
                        state_nx_s = RUN;
                    end
                end else begin
                    state_nx_s = RUN;
                end
            end
            FLUSH1: begin
                taps_nx_s      = {taps_r[4], taps_r[4:1]};
                win_valid_nx_s = 1'b1;
                state_nx_s     = FLUSH2;
            end
            FLUSH2: begin
                taps_nx_s      = {taps_r[4], taps_r[4:1]};
                win_valid_nx_s = 1'b1;
                line_done_nx_s = 1'b1;
                state_nx_s     = RUN;
            end
            default: begin
                state_nx_s = RUN;
                col_nx_s   = COL_ZERO;
            end
        endcase
        ready_nx_s = (state_nx_s == RUN);
    end

    // State, taps and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= RUN;
            col_r       <= COL_ZERO;
            taps_r      <= {5{10'd0}};
            win_valid_r <= 1'b0;
            line_done_r <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            col_r       <= col_nx_s;
            taps_r      <= taps_nx_s;
            win_valid_r <= win_valid_nx_s;
            line_done_r <= line_done_nx_s;
            ready_r     <= ready_nx_s;
        end
    end

    assign bus.corrouti1   = taps_r[0];
    assign bus.corrouti2   = taps_r[1];
    assign bus.corrouti3   = taps_r[2];
    assign bus.corrouti4   = taps_r[3];
    assign bus.corrouti5   = taps_r[4];
    assign bus.win_valid   = win_valid_r;
    assign bus.line_done   = line_done_r;
    assign bus.pixel_ready = ready_r;
endmodule
